// File: rtl/if_pc_queue.sv
// if_pc_queue: IF-stage fetch-group PC generator feeding a DEPTH-entry FIFO.
// Define IF_ADEF_CHECK_EN to keep misaligned targets and flag them on out_adef.
module if_pc_queue #(
  parameter logic [31:0] RESET_PC    = 32'h1C000000,
  parameter int          FETCH_WIDTH = 2,
  parameter int          DEPTH       = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             excp_flush,
  input  logic                             excp_tlbrefill,
  input  logic [31:0]                      eentry,
  input  logic [31:0]                      tlbentry,
  input  logic                             ertn_flush,
  input  logic [31:0]                      era,
  input  logic                             br_flush,
  input  logic [31:0]                      br_target,
  input  logic                             stall,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [31:0]                      out_pc,
  output logic [FETCH_WIDTH-1:0]           out_mask,
  output logic                             out_adef,
  output logic [$clog2(DEPTH+1)-1:0]       count
);
  localparam int GB = 4 * FETCH_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [31:0] GB_MASK = 32'(GB - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
`ifdef IF_ADEF_CHECK_EN
  localparam logic [31:0] PC_KEEP = 32'hFFFFFFFF;
`else
  localparam logic [31:0] PC_KEEP = 32'hFFFFFFFC;
`endif

  logic [31:0]            gen_pc, target, slot, next_pc;
  logic                   redirect, enq, deq, adef, hold;
  logic [FETCH_WIDTH-1:0] mask;
  logic [31:0]            pc_mem   [DEPTH];
  logic [FETCH_WIDTH-1:0] mask_mem [DEPTH];
  logic                   adef_mem [DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          cnt;

  assign out_valid = cnt != '0;
  assign count     = cnt;
  assign out_pc    = out_valid ? pc_mem[rd_ptr] : '0;
  assign out_mask  = out_valid ? mask_mem[rd_ptr] : '0;
  assign out_adef  = out_valid & adef_mem[rd_ptr];

  always_comb begin
    redirect = excp_flush | ertn_flush | br_flush;
    target   = excp_flush ? (excp_tlbrefill ? tlbentry : eentry) : ertn_flush ? era : br_target;
    slot     = (gen_pc >> 2) & 32'(FETCH_WIDTH - 1);
    next_pc  = (gen_pc & ~GB_MASK) + 32'(GB);
    enq      = !redirect && !stall && !hold && cnt < FULL;
    deq      = !redirect && out_valid && out_ready;
    mask     = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) mask[i] = 32'(i) >= slot;
  end

`ifdef IF_ADEF_CHECK_EN
  assign adef = gen_pc[1:0] != 2'b00;
  // A misaligned group stops generation until software redirects fetch.
  always_ff @(posedge clk or posedge reset)
    if (reset) hold <= 1'b0;
    else if (redirect) hold <= 1'b0;
    else if (enq && adef) hold <= 1'b1;
`else
  assign adef = 1'b0;
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      gen_pc <= RESET_PC & PC_KEEP;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (redirect) begin
      gen_pc <= target & PC_KEEP;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) begin
        gen_pc <= next_pc;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(enq) - CW'(deq);
    end

  always_ff @(posedge clk)
    if (enq) begin
      pc_mem[wr_ptr]   <= gen_pc;
      mask_mem[wr_ptr] <= mask;
      adef_mem[wr_ptr] <= adef;
    end
endmodule

// File: tb/tb_if_pc_queue.sv
// tb_if_pc_queue: directed and random checks of if_pc_queue against a queue-based model.
module tb_if_pc_queue;
  localparam int FW = 2;
  localparam int DEPTH = 4;
  localparam int GB = 4 * FW;
  localparam logic [31:0] RST_PC = 32'h1C000000;
`ifdef IF_ADEF_CHECK_EN
  localparam bit ADEF = 1'b1;
`else
  localparam bit ADEF = 1'b0;
`endif

  logic clk = 0, reset = 0;
  logic excp_flush = 0, excp_tlbrefill = 0, ertn_flush = 0, br_flush = 0, stall = 0, out_ready = 1;
  logic [31:0] eentry = 0, tlbentry = 0, era = 0, br_target = 0;
  logic out_valid, out_adef;
  logic [31:0] out_pc;
  logic [FW-1:0] out_mask;
  logic [2:0] count;
  int tests = 0, fails = 0;

  if_pc_queue #(.RESET_PC(RST_PC), .FETCH_WIDTH(FW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .excp_flush(excp_flush), .excp_tlbrefill(excp_tlbrefill),
    .eentry(eentry), .tlbentry(tlbentry), .ertn_flush(ertn_flush), .era(era),
    .br_flush(br_flush), .br_target(br_target), .stall(stall), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_mask(out_mask), .out_adef(out_adef),
    .count(count));

  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; logic [FW-1:0] mask; logic adef;} ent_t;
  ent_t q[$];
  ent_t e;
  logic [31:0] m_gen = RST_PC, t;
  bit m_hold = 0, do_enq, do_deq;
  int off;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a queue of fetch groups plus the next group address.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_gen = RST_PC;
      m_hold = 0;
    end else if (excp_flush || ertn_flush || br_flush) begin
      t = excp_flush ? (excp_tlbrefill ? tlbentry : eentry) : (ertn_flush ? era : br_target);
      m_gen = ADEF ? t : {t[31:2], 2'b00};
      q.delete();
      m_hold = 0;
    end else begin
      do_enq = !stall && q.size() < DEPTH && !m_hold;
      do_deq = q.size() != 0 && out_ready;
      if (do_deq) void'(q.pop_front());
      if (do_enq) begin
        e.pc = m_gen;
        off = int'((m_gen % GB) / 4);
        for (int i = 0; i < FW; i++) e.mask[i] = i >= off;
        e.adef = ADEF && m_gen[1:0] != 0;
        q.push_back(e);
        if (e.adef) m_hold = 1;
        m_gen = m_gen - (m_gen % GB) + GB;
      end
    end
  end

  always @(negedge clk) begin
    chk("count", 32'(count), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("out_pc", out_pc, q.size() != 0 ? q[0].pc : 32'h0);
    chk("out_mask", 32'(out_mask), q.size() != 0 ? 32'(q[0].mask) : 32'h0);
    chk("out_adef", 32'(out_adef), q.size() != 0 ? 32'(q[0].adef) : 32'h0);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_valid", 32'(out_valid), 0);
    tick(2);
    reset = 0;
  endtask

  task automatic branch(input logic [31:0] tgt);
    br_target = tgt;
    br_flush = 1;
    tick();
    br_flush = 0;
  endtask

  initial begin
    #1 reset = 1;
    tick(3);
    chk("rst_pc", out_pc, 0);
    chk("rst_mask", 32'(out_mask), 0);
    reset = 0;
    tick();
    chk("seq0", out_pc, 32'h1C000000);
    chk("seq0_mask", 32'(out_mask), 32'h3);
    tick();
    chk("seq1", out_pc, 32'h1C000008);
    tick();
    chk("seq2", out_pc, 32'h1C000010);

    do_reset();
    out_ready = 0;
    tick(8);
    chk("sat_count", 32'(count), 4);
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      chk("drain_order", out_pc, 32'h1C000000 + 32'(8 * i));
      tick();
    end

    do_reset();
    out_ready = 0;
    tick(3);
    chk("pre_br_count", 32'(count), 3);
    branch(32'h1C000104);
    chk("br_flush_count", 32'(count), 0);
    tick();
    chk("br_head", out_pc, 32'h1C000104);
    chk("br_mask", 32'(out_mask), 32'h2);
    out_ready = 1;
    tick();
    chk("br_next", out_pc, 32'h1C000108);
    chk("br_next_mask", 32'(out_mask), 32'h3);

    tlbentry = 32'h1C001000; eentry = 32'h1C002000; era = 32'h1C003000; br_target = 32'h1C004000;
    for (int k = 0; k < 2; k++) begin
      excp_tlbrefill = k == 0;
      {excp_flush, ertn_flush, br_flush} = 3'b111;
      tick();
      {excp_flush, ertn_flush, br_flush} = 3'b000;
      tick();
      chk("prio_head", out_pc, k == 0 ? 32'h1C001000 : 32'h1C002000);
    end
    excp_tlbrefill = 0;

    out_ready = 0;
    branch(32'h1C000200);
    tick(5);
    chk("stall_full", 32'(count), 4);
    stall = 1;
    out_ready = 1;
    tick(6);
    chk("stall_count", 32'(count), 0);
    chk("stall_valid", 32'(out_valid), 0);
    chk("stall_pc", out_pc, 0);
    stall = 0;
    tick();
    chk("stall_resume", out_pc, 32'h1C000220);

    branch(32'h1C000102);
    tick();
    chk("adef_pc", out_pc, ADEF ? 32'h1C000102 : 32'h1C000100);
    chk("adef_flag", 32'(out_adef), 32'(ADEF));
    tick(3);
    chk("adef_hold", 32'(count), ADEF ? 0 : 1);

    out_ready = 0;
    branch(32'hFFFFFFF8);
    tick();
    out_ready = 1;
    chk("wrap_head", out_pc, 32'hFFFFFFF8);
    tick();
    chk("wrap_next", out_pc, 32'h00000000);

    for (int n = 0; n < 600; n++) begin
      excp_flush = $urandom_range(0, 29) == 0;
      excp_tlbrefill = $urandom_range(0, 1) == 1;
      ertn_flush = $urandom_range(0, 24) == 0;
      br_flush = $urandom_range(0, 14) == 0;
      eentry = $urandom;
      tlbentry = $urandom_range(0, 1) ? $urandom : 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
      era = $urandom;
      br_target = $urandom_range(0, 3) == 0 ? $urandom : {$urandom, 2'b00} >> 2 << 2;
      stall = $urandom_range(0, 3) == 0;
      out_ready = $urandom_range(0, 2) != 0;
      tick();
    end
    {excp_flush, ertn_flush, br_flush, stall} = 4'b0;
    do_reset();
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
